// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding, oversampling
// constants and the baud-tick divider calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_t;

    localparam int TICKS_PER_BIT = 32'sd16;
    localparam int MID_BIT_TICK  = 32'sd8;

    // Rounded clk-per-tick divider, clamped so very fast baud rates still tick every clock.
    function automatic int clks_per_tick(input int sys_clk_freq, input int baud_rate);
        longint v;
        v = (longint'(sys_clk_freq) + 64'sd8 * longint'(baud_rate)) / (64'sd16 * longint'(baud_rate));
        if (v < 64'sd1) begin
            v = 64'sd1;
        end else begin
            v = v;
        end
        return int'(v);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; flags derive from the occupancy
// counter so a simultaneous push and pop while full is handled cleanly.
module uart_rx_fifo #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_data,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_data,
    output logic                  o_empty,
    output logic                  o_full,
    output logic [ADDR_WIDTH:0]   o_count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  w_do_pop;
    logic                  w_do_push;

    assign w_do_pop  = i_pop && (r_count != {(ADDR_WIDTH+1){1'b0}});
    assign w_do_push = i_push && ((r_count != DEPTH_CNT) || w_do_pop);

    // Storage, pointers and occupancy; pointers wrap naturally at the depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
            r_wr_ptr <= {ADDR_WIDTH{1'b0}};
            r_rd_ptr <= {ADDR_WIDTH{1'b0}};
            r_count  <= {(ADDR_WIDTH+1){1'b0}};
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + {{ADDR_WIDTH{1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{ADDR_WIDTH{1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == {(ADDR_WIDTH+1){1'b0}});
    assign o_full  = (r_count == DEPTH_CNT);
    assign o_count = r_count;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: synchronises the Rx line, recovers 16x-oversampled 8N1/8E1/8O1
// frames and queues good bytes in a FWFT FIFO with sticky error flags.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int SYS_CLK_FREQ    = 100_000_000,
    parameter int BAUD_RATE       = 115200,
    parameter int DATA_BITS       = 8,
    parameter int PARITY_EN       = 0,
    parameter int PARITY_ODD      = 0,
    parameter int FIFO_ADDR_WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx,
    input  logic                       rd_en,
    output logic [7:0]                 rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [FIFO_ADDR_WIDTH:0]   count,
    input  logic                       clr_err,
    output logic                       overrun_err,
    output logic                       frame_err,
    output logic                       parity_err
);

    localparam int CLKS_PER_TICK = clks_per_tick(SYS_CLK_FREQ, BAUD_RATE);
    localparam int TCW           = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [TCW-1:0] TICK_LAST = TCW'(CLKS_PER_TICK - 1);
    localparam logic [3:0] MID_LAST = 4'(MID_BIT_TICK - 1);
    localparam logic [3:0] BIT_LAST = 4'(TICKS_PER_BIT - 1);
    localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    logic           r_rx_meta;
    logic           r_rx_sync;
    logic [TCW-1:0] r_tick_cnt;
    rx_state_t      r_state;
    logic [3:0]     r_os_cnt;
    logic [2:0]     r_bit_cnt;
    logic [7:0]     r_shift;
    logic           r_par_bad;
    logic           r_overrun;
    logic           r_frame;
    logic           r_parity;

    logic           w_tick;
    logic           w_stop_smp;
    logic           w_push;
    logic           w_pop;
    logic           w_empty;
    logic           w_full;
    logic           w_set_ovr;
    logic           w_set_frm;
    logic           w_set_par;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // Oversample tick generator, held at zero in IDLE so it restarts on the start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= {TCW{1'b0}};
        end else if (r_state == ST_IDLE) begin
            r_tick_cnt <= {TCW{1'b0}};
        end else if (w_tick) begin
            r_tick_cnt <= {TCW{1'b0}};
        end else begin
            r_tick_cnt <= r_tick_cnt + {{(TCW-1){1'b0}}, 1'b1};
        end
    end

    assign w_tick = (r_tick_cnt == TICK_LAST);

    // Frame FSM: start qualification, mid-bit sampling of data/parity/stop, break wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_os_cnt  <= 4'd0;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
            r_par_bad <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_rx_sync) begin
                        r_state   <= ST_START;
                        r_os_cnt  <= 4'd0;
                        r_bit_cnt <= 3'd0;
                        r_shift   <= 8'd0;
                        r_par_bad <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        if (r_os_cnt == MID_LAST) begin
                            r_os_cnt <= 4'd0;
                            r_state  <= r_rx_sync ? ST_IDLE : ST_DATA;
                        end else begin
                            r_os_cnt <= r_os_cnt + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_os_cnt == BIT_LAST) begin
                            r_os_cnt           <= 4'd0;
                            r_shift[r_bit_cnt] <= r_rx_sync;
                            if (r_bit_cnt == DATA_LAST) begin
                                r_state <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end else begin
                            r_os_cnt <= r_os_cnt + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_tick) begin
                        if (r_os_cnt == BIT_LAST) begin
                            r_os_cnt  <= 4'd0;
                            r_par_bad <= r_rx_sync != ((^r_shift) ^ PAR_ODD);
                            r_state   <= ST_STOP;
                        end else begin
                            r_os_cnt <= r_os_cnt + 4'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        if (r_os_cnt == BIT_LAST) begin
                            r_os_cnt <= 4'd0;
                            r_state  <= r_rx_sync ? ST_IDLE : ST_BREAK;
                        end else begin
                            r_os_cnt <= r_os_cnt + 4'd1;
                        end
                    end
                end
                ST_BREAK: begin
                    if (r_rx_sync) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_stop_smp = (r_state == ST_STOP) && w_tick && (r_os_cnt == BIT_LAST);
    assign w_push     = w_stop_smp && r_rx_sync && !r_par_bad;
    assign w_pop      = rd_en && !w_empty;
    assign w_set_ovr  = w_push && w_full && !w_pop;
    assign w_set_frm  = w_stop_smp && !r_rx_sync;
    assign w_set_par  = w_stop_smp && r_rx_sync && r_par_bad;

    // Sticky error flags; a same-cycle set outranks clr_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
            r_frame   <= 1'b0;
            r_parity  <= 1'b0;
        end else begin
            r_overrun <= w_set_ovr | (r_overrun & ~clr_err);
            r_frame   <= w_set_frm | (r_frame & ~clr_err);
            r_parity  <= w_set_par | (r_parity & ~clr_err);
        end
    end

    uart_rx_fifo #(
        .WIDTH      (8),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (r_shift),
        .i_pop   (rd_en),
        .o_data  (rd_data),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (count)
    );

    assign empty       = w_empty;
    assign full        = w_full;
    assign overrun_err = r_overrun;
    assign frame_err   = r_frame;
    assign parity_err  = r_parity;

endmodule
